// File: rtl/sr_dbus_pkg.sv
// Purpose : shared constants and types for the schoolRISCV data-side bus.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: MMIO addresses, STATUS bit positions, write-size codes, UART FSM state type.
package sr_dbus_pkg;

  // MMIO window: the upper half-word selects the window, the lower half-word the register.
  localparam logic [31:0] DBUS_MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] DBUS_TXDATA    = 32'hFFFF_0000;
  localparam logic [31:0] DBUS_STATUS    = 32'hFFFF_0004;
  localparam logic [31:0] DBUS_CYCLE     = 32'hFFFF_0008;

  localparam int STATUS_FULL    = 0;
  localparam int STATUS_EMPTY   = 1;
  localparam int STATUS_OVF     = 2;
  localparam int STATUS_BUSY    = 3;
  localparam int STATUS_CNT_LSB = 8;

  localparam logic [1:0] WSIZE_NONE = 2'b00;
  localparam logic [1:0] WSIZE_BYTE = 2'b01;
  localparam logic [1:0] WSIZE_HALF = 2'b10;
  localparam logic [1:0] WSIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sr_uart_tx.sv
// Purpose : byte FIFO feeding an 8N1 serial transmitter.
// Latency : a push into an idle, empty unit drives the start bit one edge later.
// Backpressure: pushes while full are dropped; the caller watches 'full' to flag it.
// Ports   : clk/rst, push + pushData (enqueue), full/empty/count (FIFO level),
//           busy (frame in progress), uartTx (serial line, idle high).
module sr_uart_tx
  import sr_dbus_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    pushData,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          uartTx
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CBW = $clog2(CLKS_PER_BIT);

  logic [7:0]     fifoMem [FIFO_DEPTH];
  logic [PW-1:0]  wrPtr, rdPtr;
  logic [CW-1:0]  fifoCnt;

  uart_state_t    state;
  logic [CBW-1:0] bitCnt;
  logic [2:0]     bitIdx;
  logic [7:0]     shiftReg;

  logic pushOk, pop, bitEnd;

  assign full   = (fifoCnt == CW'(FIFO_DEPTH));
  assign empty  = (fifoCnt == '0);
  assign count  = fifoCnt;
  assign busy   = (state != IDLE);
  assign bitEnd = (bitCnt == CBW'(CLKS_PER_BIT - 1));

  // Push is judged on the pre-edge full flag, so a same-cycle pop never frees room for it.
  assign pushOk = push && !full;
  // The FSM takes the next byte either from IDLE or straight out of the stop bit.
  assign pop    = !empty && ((state == IDLE) || (state == STOP && bitEnd));

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   fifoCnt <= fifoCnt + 1'b1;
        2'b01:   fifoCnt <= fifoCnt - 1'b1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      uartTx   <= 1'b1;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          uartTx <= 1'b1;
          if (!empty) begin
            shiftReg <= fifoMem[rdPtr];
            bitCnt   <= '0;
            uartTx   <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            bitCnt <= '0;
            bitIdx <= '0;
            uartTx <= shiftReg[0];
            state  <= DATA;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            bitCnt <= '0;
            if (bitIdx == 3'd7) begin
              uartTx <= 1'b1;
              state  <= STOP;
            end else begin
              // shiftReg[0] is on the line; the next bit is shiftReg[1].
              bitIdx   <= bitIdx + 1'b1;
              shiftReg <= shiftReg >> 1;
              uartTx   <= shiftReg[1];
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            bitCnt <= '0;
            if (!empty) begin
              shiftReg <= fifoMem[rdPtr];
              uartTx   <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sr_data_bus.sv
// Purpose : schoolRISCV data-side bus: byte-addressed RAM plus MMIO UART transmitter.
// Latency : rdata is combinational (same cycle); writes land at the rising edge.
// Backpressure: none toward the core; UART bytes written while the FIFO is full are dropped and latch ovf.
// Ports   : clk/rst, write_byte_en/waddr/wdata (store), raddr/rdata (load), uart_tx (serial out).
// Option  : SR_DBUS_CYCLE_COUNTER_EN adds a free-running cycle counter readable at CYCLE.
module sr_data_bus
  import sr_dbus_pkg::*;
#(
  parameter int DMEM_WORDS   = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  write_byte_en,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        uart_tx
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] mem [DMEM_WORDS];

  logic          wrEn, wrRam, wrMmio, txWr, statusWr;
  logic          rdRam, rdMmio;
  logic [3:0]    laneMask;
  logic [31:0]   laneData;
  logic          ovf, txFull, txEmpty, txBusy;
  logic [CW-1:0] txCount;
  logic [31:0]   statusWord;

  assign wrEn     = (write_byte_en != WSIZE_NONE);
  assign wrRam    = wrEn && (waddr[31:AW+2] == '0);
  assign wrMmio   = wrEn && (waddr[31:16] == DBUS_MMIO_BASE[31:16]);
  assign txWr     = wrMmio && (waddr[15:0] == DBUS_TXDATA[15:0]);
  assign statusWr = wrMmio && (waddr[15:0] == DBUS_STATUS[15:0]);

  assign rdRam    = (raddr[31:AW+2] == '0);
  assign rdMmio   = (raddr[31:16] == DBUS_MMIO_BASE[31:16]);

  // Replicate the store data across lanes so each lane simply takes its own slice.
  always_comb begin
    laneMask = 4'b0000;
    laneData = wdata;
    case (write_byte_en)
      WSIZE_BYTE: begin
        laneMask = 4'b0001 << waddr[1:0];
        laneData = {4{wdata[7:0]}};
      end
      WSIZE_HALF: begin
        laneMask = waddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wdata[15:0]}};
      end
      WSIZE_WORD: laneMask = 4'b1111;
      default:    laneMask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wrRam) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMask[i]) mem[waddr[AW+1:2]][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  // A new overflow outranks a same-cycle clear so no drop goes unreported.
  always_ff @(posedge clk) begin
    if (rst)                               ovf <= 1'b0;
    else if (txWr && txFull)               ovf <= 1'b1;
    else if (statusWr && wdata[STATUS_OVF]) ovf <= 1'b0;
  end

  sr_uart_tx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clk     (clk),
    .rst     (rst),
    .push    (txWr),
    .pushData(wdata[7:0]),
    .full    (txFull),
    .empty   (txEmpty),
    .count   (txCount),
    .busy    (txBusy),
    .uartTx  (uart_tx)
  );

  always_comb begin
    statusWord                                = '0;
    statusWord[STATUS_FULL]                   = txFull;
    statusWord[STATUS_EMPTY]                  = txEmpty;
    statusWord[STATUS_OVF]                    = ovf;
    statusWord[STATUS_BUSY]                   = txBusy;
    statusWord[STATUS_CNT_LSB +: 4]           = 4'(txCount);
  end

`ifdef SR_DBUS_CYCLE_COUNTER_EN
  logic [31:0] cycleCnt;

  always_ff @(posedge clk) begin
    if (rst) cycleCnt <= '0;
    else     cycleCnt <= cycleCnt + 32'd1;
  end
`endif

  always_comb begin
    rdata = '0;
    if (rdRam) begin
      rdata = mem[raddr[AW+1:2]];
    end else if (rdMmio) begin
      case (raddr[15:0])
        DBUS_STATUS[15:0]: rdata = statusWord;
`ifdef SR_DBUS_CYCLE_COUNTER_EN
        DBUS_CYCLE[15:0]:  rdata = cycleCnt;
`endif
        default:           rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_data_bus.sv
// Purpose : directed self-checking bench for sr_data_bus (RAM lanes, UART framing, FIFO/ovf, reset).
// Latency : checks the one-edge start-bit latency and 10-bit frame timing at CLKS_PER_BIT=4.
// Backpressure: exercises FIFO full, dropped push and sticky overflow clear.
module tb_sr_data_bus;
  import sr_dbus_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write_byte_en;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rxQ [$];
  int         rxT [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_data_bus #(
    .DMEM_WORDS  (1024),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_byte_en(write_byte_en),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .uart_tx      (uart_tx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write_byte_en = sz;
    waddr         = a;
    wdata         = d;
    @(posedge clk);
    #1;
    write_byte_en = WSIZE_NONE;
  endtask

  // Serial receiver: samples each bit in its middle and logs byte plus start cycle.
  initial begin : monitor
    logic [7:0] b;
    int         t;
    b = '0;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && rst === 1'b0) begin
        t = cyc;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        repeat (CPB - 3) @(negedge clk);
        rxQ.push_back(b);
        rxT.push_back(t);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] c1, c2;
    logic [9:0]  frm;
    logic [7:0]  burst [11];
    int          n;

    for (int i = 0; i < 11; i++) burst[i] = 8'(8'h41 + i);

    rst           = 1'b1;
    write_byte_en = WSIZE_NONE;
    waddr         = '0;
    wdata         = '0;
    raddr         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(uart_tx), 32'h1);
    raddr = DBUS_STATUS; #1;
    chk("rst_status", rdata, 32'h0000_0002);
    raddr = DBUS_TXDATA; #1;
    chk("txdata_rd_zero", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // RAM lanes
    wr(WSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    write_byte_en = WSIZE_BYTE; waddr = 32'h12; wdata = 32'hFFFF_FF55; raddr = 32'h10;
    #1;
    chk("rd_before_wr", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    write_byte_en = WSIZE_NONE;
    chk("byte_wr", rdata, 32'hDE55_BEEF);
    raddr = 32'h13; #1;
    chk("rd_low_bits_ignored", rdata, 32'hDE55_BEEF);

    wr(WSIZE_WORD, 32'h20, 32'h0);
    wr(WSIZE_HALF, 32'h22, 32'hAAAA_1234);
    raddr = 32'h20; #1;
    chk("half_wr_hi", rdata, 32'h1234_0000);
    wr(WSIZE_NONE, 32'h20, 32'hFFFF_FFFF);
    chk("no_write", rdata, 32'h1234_0000);
    wr(WSIZE_HALF, 32'h21, 32'hBBBB_5678);
    chk("half_wr_lo_a0_ignored", rdata, 32'h1234_5678);
    wr(WSIZE_WORD, 32'h0001_0000, 32'hCAFE_F00D);
    raddr = 32'h0001_0000; #1;
    chk("unmapped_rd", rdata, 32'h0);
    raddr = 32'h0; #1;
    chk("unmapped_wr_no_alias", rdata === 32'hCAFE_F00D ? 32'h1 : 32'h0, 32'h0);

    // Single frame 0xA5
    @(negedge clk);
    write_byte_en = WSIZE_WORD; waddr = DBUS_TXDATA; wdata = 32'hFFFF_FFA5;
    @(posedge clk); #1;
    write_byte_en = WSIZE_NONE;
    raddr = DBUS_STATUS;
    @(negedge clk);
    chk("tx_after_e0", 32'(uart_tx), 32'h1);
    chk("status_after_e0", rdata, 32'h0000_0100);
    @(negedge clk);
    chk("status_after_e1", rdata, 32'h0000_000A);
    frm = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("a5_bit%0d", k), 32'(uart_tx), 32'(frm[k]));
      repeat (CPB) @(negedge clk);
    end
    chk("a5_done_status", rdata, 32'h0000_0002);
    chk("a5_done_tx", 32'(uart_tx), 32'h1);

    // Burst, FIFO full and overflow
    rxQ.delete();
    rxT.delete();
    wr(WSIZE_WORD, DBUS_TXDATA, 32'(burst[0]));
    wr(WSIZE_BYTE, DBUS_TXDATA, 32'(burst[1]));
    chk("push_pop_same_cycle", rdata, 32'h0000_0108);
    n = 0;
    while (rdata[11:8] != 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 200), 32'h1);
    for (int i = 2; i < 10; i++) wr(WSIZE_WORD, DBUS_TXDATA, 32'(burst[i]));
    chk("fifo_full", rdata, 32'h0000_0809);
    wr(WSIZE_WORD, DBUS_TXDATA, 32'(burst[10]));
    chk("ovf_set", rdata, 32'h0000_080D);
    wr(WSIZE_WORD, DBUS_STATUS, 32'h4);
    chk("ovf_clear", rdata, 32'h0000_0809);
    n = 0;
    while (rxQ.size() < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_count", 32'(rxQ.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < rxQ.size()) chk($sformatf("rx_byte%0d", i), 32'(rxQ[i]), 32'(burst[i]));
    end
    for (int i = 1; i < 10; i++) begin
      if (i < rxT.size()) chk($sformatf("rx_gap%0d", i), 32'(rxT[i] - rxT[i-1]), 32'd40);
    end
    n = 0;
    while (rdata[STATUS_BUSY] && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
    chk("burst_idle_status", rdata, 32'h0000_0002);
    chk("dropped_not_sent", 32'(rxQ.size()), 32'd10);

    // Cycle counter window
    @(negedge clk);
    raddr = DBUS_CYCLE; #1;
    c1 = rdata;
    repeat (7) @(negedge clk);
    #1;
    c2 = rdata;
`ifdef SR_DBUS_CYCLE_COUNTER_EN
    chk("cycle_delta", c2 - c1, 32'd7);
`else
    chk("cycle_off_a", c1, 32'h0);
    chk("cycle_off_b", c2, 32'h0);
`endif

    // Reset in the middle of a data bit
    raddr = DBUS_STATUS;
    wr(WSIZE_WORD, DBUS_TXDATA, 32'h3C);
    wr(WSIZE_WORD, DBUS_TXDATA, 32'h77);
    repeat (8) @(negedge clk);
    chk("pre_rst_tx_low", 32'(uart_tx), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'(uart_tx), 32'h1);
    chk("rst_mid_status", rdata, 32'h0000_0002);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_tx_idle", 32'(uart_tx), 32'h1);
    chk("post_rst_status", rdata, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
